// File: rtl/fetch_buffer_if.sv
// Fetch-to-decode handshake bundle: push side from the fetch stage, pop side into decode.
interface fetch_buffer_if #(
  parameter int DATA_W = 32,
  parameter int EXC_W  = 8
);
  logic              flush;
  logic              push_valid;
  logic              push_ready;
  logic [DATA_W-1:0] push_pc;
  logic [DATA_W-1:0] push_instr;
  logic [EXC_W-1:0]  push_except;
  logic              push_ds;
  logic              pop_valid;
  logic              pop_ready;
  logic [DATA_W-1:0] pop_pc;
  logic [DATA_W-1:0] pop_instr;
  logic [EXC_W-1:0]  pop_except;
  logic              pop_ds;

  modport slave (
    input  flush, push_valid, push_pc, push_instr, push_except, push_ds, pop_ready,
    output push_ready, pop_valid, pop_pc, pop_instr, pop_except, pop_ds
  );

  modport master (
    output flush, push_valid, push_pc, push_instr, push_except, push_ds, pop_ready,
    input  push_ready, pop_valid, pop_pc, pop_instr, pop_except, pop_ds
  );
endinterface

// File: rtl/fetch_buffer.sv
// Instruction prefetch FIFO between fetch and decode, with flush and optional
// zero-latency bypass when empty.
module fetch_buffer #(
  parameter int DATA_W = 32,
  parameter int EXC_W  = 8,
  parameter int DEPTH  = 4,
  parameter bit BYPASS = 1'b0,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  fetch_buffer_if.slave    bus,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_pc     [DEPTH];
  logic [DATA_W-1:0] mem_instr  [DEPTH];
  logic [EXC_W-1:0]  mem_except [DEPTH];
  logic              mem_ds     [DEPTH];

  logic [PTR_W:0]    rd_ptr, wr_ptr;
  logic [PTR_W-1:0]  rd_idx, wr_idx;
  logic              push_fire, pop_fire, bypass_active, wr_en, rd_en;

  assign rd_idx = rd_ptr[PTR_W-1:0];
  assign wr_idx = wr_ptr[PTR_W-1:0];

  assign empty = (rd_ptr == wr_ptr);
  assign full  = (rd_idx == wr_idx) && (rd_ptr[PTR_W] != wr_ptr[PTR_W]);

  // push_ready deliberately ignores pop_ready: a full buffer never accepts.
  assign bus.push_ready = ~full & ~bus.flush;
  assign push_fire      = bus.push_valid & bus.push_ready;
  assign bypass_active  = BYPASS && empty && push_fire;

  assign bus.pop_valid  = ~bus.flush & (~empty | bypass_active);
  assign pop_fire       = bus.pop_valid & bus.pop_ready;

  // A bypassed entry that decode takes immediately is never stored.
  assign wr_en = push_fire & ~(bypass_active & bus.pop_ready);
  assign rd_en = pop_fire & ~bypass_active;

  always_comb begin
    bus.pop_pc     = mem_pc[rd_idx];
    bus.pop_instr  = mem_instr[rd_idx];
    bus.pop_except = mem_except[rd_idx];
    bus.pop_ds     = mem_ds[rd_idx];
    if (bypass_active) begin
      bus.pop_pc     = bus.push_pc;
      bus.pop_instr  = bus.push_instr;
      bus.pop_except = bus.push_except;
      bus.pop_ds     = bus.push_ds;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_pc[i]     <= '0;
        mem_instr[i]  <= '0;
        mem_except[i] <= '0;
        mem_ds[i]     <= 1'b0;
      end
    end else if (bus.flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        mem_pc[wr_idx]     <= bus.push_pc;
        mem_instr[wr_idx]  <= bus.push_instr;
        mem_except[wr_idx] <= bus.push_except;
        mem_ds[wr_idx]     <= bus.push_ds;
        wr_ptr             <= wr_ptr + (PTR_W + 1)'(1);
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + (PTR_W + 1)'(1);
      end
      case ({wr_en, rd_en})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: tb/tb_fetch_buffer.sv
// Directed table-driven bench for fetch_buffer (DEPTH=4), one plain and one bypass instance.
module tb_fetch_buffer;
  localparam logic [31:0] B    = 32'hBFC0_0000;
  localparam logic [31:0] MASK = 32'h5A5A_5A5A;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] count0, count1;
  logic       full0, full1, empty0, empty1;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  fetch_buffer_if #(.DATA_W(32), .EXC_W(8)) bus0 ();
  fetch_buffer_if #(.DATA_W(32), .EXC_W(8)) bus1 ();

  fetch_buffer #(.DATA_W(32), .EXC_W(8), .DEPTH(4), .BYPASS(1'b0)) u_dut (
    .clk(clk), .rst(rst), .bus(bus0), .count(count0), .full(full0), .empty(empty0)
  );

  fetch_buffer #(.DATA_W(32), .EXC_W(8), .DEPTH(4), .BYPASS(1'b1)) u_byp (
    .clk(clk), .rst(rst), .bus(bus1), .count(count1), .full(full1), .empty(empty1)
  );

  typedef struct {
    logic        pv;
    logic [31:0] pc;
    logic        pr;
    logic        fl;
    logic        e_pv;
    logic [31:0] e_pc;
    logic        e_prdy;
    logic [2:0]  e_cnt;
    logic        e_full;
    logic        e_empty;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic pv, input logic [31:0] pc, input logic pr, input logic fl,
                     input logic e_pv, input logic [31:0] e_pc, input logic e_prdy,
                     input logic [2:0] e_cnt, input logic e_full, input logic e_empty);
    vec_t v;
    v.pv = pv; v.pc = pc; v.pr = pr; v.fl = fl;
    v.e_pv = e_pv; v.e_pc = e_pc; v.e_prdy = e_prdy;
    v.e_cnt = e_cnt; v.e_full = e_full; v.e_empty = e_empty;
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h expected=%0h", nm, got, exp);
    end
  endtask

  task automatic drive0(input logic pv, input logic [31:0] pc, input logic [7:0] exc,
                        input logic ds, input logic pr, input logic fl);
    bus0.push_valid  = pv;
    bus0.push_pc     = pc;
    bus0.push_instr  = pc ^ MASK;
    bus0.push_except = exc;
    bus0.push_ds     = ds;
    bus0.pop_ready   = pr;
    bus0.flush       = fl;
  endtask

  task automatic drive1(input logic pv, input logic [31:0] pc, input logic pr, input logic fl);
    bus1.push_valid  = pv;
    bus1.push_pc     = pc;
    bus1.push_instr  = pc ^ MASK;
    bus1.push_except = 8'h00;
    bus1.push_ds     = 1'b0;
    bus1.pop_ready   = pr;
    bus1.flush       = fl;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive0(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    drive1(1'b0, '0, 1'b0, 1'b0);

    // Fill, refused 5th push, drain, empty pop
    add(1, B+32'h00, 0, 0,  0, 0,          1, 3'd0, 0, 1);
    add(1, B+32'h04, 0, 0,  1, B+32'h00,   1, 3'd1, 0, 0);
    add(1, B+32'h08, 0, 0,  1, B+32'h00,   1, 3'd2, 0, 0);
    add(1, B+32'h0C, 0, 0,  1, B+32'h00,   1, 3'd3, 0, 0);
    add(1, B+32'h10, 0, 0,  1, B+32'h00,   0, 3'd4, 1, 0);
    add(0, 0,        1, 0,  1, B+32'h00,   0, 3'd4, 1, 0);
    add(0, 0,        1, 0,  1, B+32'h04,   1, 3'd3, 0, 0);
    add(0, 0,        1, 0,  1, B+32'h08,   1, 3'd2, 0, 0);
    add(0, 0,        1, 0,  1, B+32'h0C,   1, 3'd1, 0, 0);
    add(0, 0,        1, 0,  0, 0,          1, 3'd0, 0, 1);
    // Streaming across the pointer wrap
    add(1, B+32'h20, 0, 0,  0, 0,          1, 3'd0, 0, 1);
    for (int k = 0; k < 10; k++)
      add(1, B+32'h24+32'(4*k), 1, 0,  1, B+32'h20+32'(4*k), 1, 3'd1, 0, 0);
    add(0, 0,        1, 0,  1, B+32'h48,   1, 3'd1, 0, 0);
    // Flush at count=3 with a same-cycle push
    add(1, B+32'hC0, 0, 0,  0, 0,          1, 3'd0, 0, 1);
    add(1, B+32'hC4, 0, 0,  1, B+32'hC0,   1, 3'd1, 0, 0);
    add(1, B+32'hC8, 0, 0,  1, B+32'hC0,   1, 3'd2, 0, 0);
    add(1, B+32'hCC, 1, 1,  0, 0,          0, 3'd3, 0, 0);
    add(1, B+32'hD0, 0, 0,  0, 0,          1, 3'd0, 0, 1);
    add(0, 0,        1, 0,  1, B+32'hD0,   1, 3'd1, 0, 0);
    add(0, 0,        0, 0,  0, 0,          1, 3'd0, 0, 1);

    repeat (3) @(posedge clk);
    #1;
    chk("reset empty",      64'(empty0), 64'd1);
    chk("reset full",       64'(full0), 64'd0);
    chk("reset count",      64'(count0), 64'd0);
    chk("reset pop_valid",  64'(bus0.pop_valid), 64'd0);
    chk("reset push_ready", 64'(bus0.push_ready), 64'd1);
    rst = 1'b1;
    next_cycle();

    foreach (tbl[i]) begin
      drive0(tbl[i].pv, tbl[i].pc, 8'h00, 1'b0, tbl[i].pr, tbl[i].fl);
      #2;
      chk($sformatf("row%0d pop_valid", i), 64'(bus0.pop_valid), 64'(tbl[i].e_pv));
      if (tbl[i].e_pv) begin
        chk($sformatf("row%0d pop_pc", i), 64'(bus0.pop_pc), 64'(tbl[i].e_pc));
        chk($sformatf("row%0d pop_instr", i), 64'(bus0.pop_instr), 64'(tbl[i].e_pc ^ MASK));
      end
      chk($sformatf("row%0d push_ready", i), 64'(bus0.push_ready), 64'(tbl[i].e_prdy));
      chk($sformatf("row%0d count", i), 64'(count0), 64'(tbl[i].e_cnt));
      chk($sformatf("row%0d full", i), 64'(full0), 64'(tbl[i].e_full));
      chk($sformatf("row%0d empty", i), 64'(empty0), 64'(tbl[i].e_empty));
      next_cycle();
    end
    drive0(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);

    // Bypass: consumed in the same cycle, never stored
    drive1(1'b1, B+32'h100, 1'b1, 1'b0);
    #2;
    chk("byp pop_valid", 64'(bus1.pop_valid), 64'd1);
    chk("byp pop_pc",    64'(bus1.pop_pc), 64'(B+32'h100));
    chk("byp pop_instr", 64'(bus1.pop_instr), 64'((B+32'h100) ^ MASK));
    chk("byp count",     64'(count1), 64'd0);
    next_cycle();
    drive1(1'b0, '0, 1'b0, 1'b0);
    #1;
    chk("byp count after", 64'(count1), 64'd0);
    chk("byp empty after", 64'(empty1), 64'd1);
    // Bypass not accepted: entry is stored
    drive1(1'b1, B+32'h100, 1'b0, 1'b0);
    #1;
    chk("byp2 pop_valid", 64'(bus1.pop_valid), 64'd1);
    chk("byp2 pop_pc",    64'(bus1.pop_pc), 64'(B+32'h100));
    next_cycle();
    drive1(1'b0, '0, 1'b0, 1'b0);
    #1;
    chk("byp2 count",     64'(count1), 64'd1);
    chk("byp2 stored pc", 64'(bus1.pop_pc), 64'(B+32'h100));
    // Flush beats both the stored head and a bypass candidate
    drive1(1'b1, B+32'h200, 1'b1, 1'b1);
    #1;
    chk("bypfl pop_valid",  64'(bus1.pop_valid), 64'd0);
    chk("bypfl push_ready", 64'(bus1.push_ready), 64'd0);
    next_cycle();
    #1;
    chk("bypfl2 pop_valid", 64'(bus1.pop_valid), 64'd0);
    next_cycle();
    drive1(1'b0, '0, 1'b0, 1'b0);
    #1;
    chk("bypfl count", 64'(count1), 64'd0);
    chk("bypfl empty", 64'(empty1), 64'd1);

    // Exception payload and delay-slot flag round trip
    drive0(1'b1, B+32'hE0, 8'h80, 1'b1, 1'b0, 1'b0);
    next_cycle();
    drive0(1'b1, B+32'hF0, 8'h01, 1'b0, 1'b0, 1'b0);
    #1;
    chk("exc pop_valid",  64'(bus0.pop_valid), 64'd1);
    chk("exc pop_pc",     64'(bus0.pop_pc), 64'(B+32'hE0));
    chk("exc pop_except", 64'(bus0.pop_except), 64'h80);
    chk("exc pop_ds",     64'(bus0.pop_ds), 64'd1);
    chk("exc count",      64'(count0), 64'd1);
    next_cycle();
    drive0(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("pre-reset count", 64'(count0), 64'd2);
    // Asynchronous reset mid-cycle, checked before any clock edge
    rst = 1'b0;
    #1;
    chk("async count",     64'(count0), 64'd0);
    chk("async pop_valid", 64'(bus0.pop_valid), 64'd0);
    chk("async empty",     64'(empty0), 64'd1);
    chk("async full",      64'(full0), 64'd0);
    next_cycle();
    rst = 1'b1;
    next_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule

// File: doc/fetch_buffer.md
Name: fetch_buffer

Overview:
- Parametrised instruction prefetch queue between the fetch stage (PC register plus instruction memory port) and the decode pipeline register.
- Replaces the single fixed F→D register pair with a DEPTH-entry FIFO. Each entry carries {pc, instr, except, delayslot}, so the I-side can keep fetching while decode is stalled.
- Supports whole-queue flush on branch redirect or exception.
- Supports an optional zero-latency bypass when the queue is empty.

Parameters:
- DATA_W, 32, width of pc and instr fields.
- EXC_W, 8, width of the per-instruction exception code vector.
- DEPTH, 4, number of entries; power of two, ≥2.
- BYPASS, 0, 1 = an empty queue forwards the push combinationally to the pop side in the same cycle.
- CNT_W, $clog2(DEPTH+1), width of the occupancy counter.

Ports:
- clk  in  1  pipeline clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-low reset (asserted at 0).
- flush  in  1  discard all entries and the same-cycle push (branch redirect / flush_except).
- push_valid  in  1  fetch has a returned instruction.
- push_ready  out  1  buffer can accept a push this cycle.
- push_pc  in  DATA_W  fetch address.
- push_instr  in  DATA_W  fetched instruction word.
- push_except  in  EXC_W  fetch-stage exception vector (bit EXC_W-1 = AdEL on fetch).
- push_ds  in  1  instruction is in a branch delay slot.
- pop_valid  out  1  head entry is available to decode.
- pop_ready  in  1  decode accepts the head (driven by ~stallD).
- pop_pc  out  DATA_W  head pc.
- pop_instr  out  DATA_W  head instruction.
- pop_except  out  EXC_W  head exception vector.
- pop_ds  out  1  head delay-slot flag.
- count  out  CNT_W  current number of stored entries.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.

Behaviour:
- Storage: circular array of DEPTH entries; rd_ptr and wr_ptr are log2(DEPTH)+1 bits wide, with the MSB used as the wrap flag.
  - empty = pointers equal.
  - full = low bits equal and MSBs differ.
- Reset (rst=0, asynchronous): rd_ptr = wr_ptr = 0, count = 0, empty = 1, full = 0, pop_valid = 0. Payload outputs are don't-care but must not be X-propagating; entry RAM is reset to 0.
- Handshakes:
  - Push fires when push_valid & push_ready.
  - Pop fires when pop_valid & pop_ready.
  - push_ready = ~full & ~flush. A full buffer does not accept a push even if a pop fires the same cycle; no combinational ready-through.
- Latency:
  - BYPASS=0: a pushed entry appears on pop_* the cycle after the push, so minimum latency is 1 clk.
  - BYPASS=1: when empty & push fires & ~flush, pop_valid = 1 and pop_* = push_* combinationally in the same cycle.
    - If pop_ready is also 1, the entry is consumed and never written; count is unchanged.
    - Otherwise the entry is written normally.
- Simultaneous push and pop (not full, not flush): both pointers advance and count is unchanged.
- Pop from an empty buffer (BYPASS=0, or BYPASS=1 with no push): ignored; pointers do not move.
- Flush has priority over everything:
  - Next state: rd_ptr = wr_ptr = 0, count = 0.
  - During the flush cycle: pop_valid = 0, push_ready = 0, and the same-cycle push is dropped.
- Wrap-around: pointer low bits roll from DEPTH-1 to 0 and the MSB toggles; data order is preserved across the wrap.
- count:
  - +1 on push-only.
  - −1 on pop-only.
  - Hold on both or neither.
  - Never exceeds DEPTH, never underflows.
- Outputs pop_* are driven from the head entry (registered storage) when not bypassing; there is no combinational path from pop_ready to any output.

Test Plan:
- Reset then idle: hold rst=0 for 3 clk, release → empty=1, full=0, count=0, pop_valid=0, push_ready=1.
- Fill and drain (DEPTH=4, BYPASS=0):
  - Push pc 0xBFC00000..0xBFC0000C with pop_ready=0 → count 1,2,3,4, full=1, push_ready=0.
  - A 5th push is refused.
  - Raise pop_ready → pops in order 0xBFC00000, …04, …08, …0C over 4 clk, then empty=1.
- Streaming with wrap-around: continuous push and pop for 10 clk after 1 preload → count stays 1, and pc sequence out equals pc sequence in delayed 1 clk across the pointer wrap.
- Flush mid-stream:
  - With count=3, assert flush with push_valid=1 → next clk count=0, empty=1.
  - In the flush cycle pop_valid=0, and the flushed push never appears.
  - Pushes resume on the following clk.
- Bypass (BYPASS=1): empty, push pc 0xBFC00100 with pop_ready=1 → pop_valid=1 and pop_pc=0xBFC00100 the same cycle, count stays 0. Same push with pop_ready=0 → count=1 next clk.
- Exception payload plus async reset:
  - Push push_except=8'h80, push_ds=1 → popped with identical values.
  - Drop rst to 0 mid-cycle while count=2 → count=0 and pop_valid=0 immediately, without waiting for a clock edge.
